scara_joint_sequencer: RTL and testbench
========================================

SCARA_JOINT_SEQUENCER -- requirements
Module: scara_joint_sequencer

Interface
REQ-001 SHALL have parameter NJ, default 2: joint count, 1..8.
REQ-002 SHALL have parameter ANG_W, default 14: signed two's-complement angle width.
REQ-003 SHALL have parameter STEP_W, default 8: per-beat step-count width.
REQ-004 SHALL have parameter SHIFT, default 2: one motor step = 2^SHIFT angle LSBs.
REQ-005 SHALL have parameter HOME_ANGLE, default 0: reset angle, all joints.
REQ-006 SHALL have parameter DWELL_CYCLES, default 200: dwell length in clocks.
REQ-007 clk  in  1  single clock; all logic on its rising edge.
REQ-008 reset  in  1  synchronous, active-high.
REQ-009 cmd_valid  in  1  command offered.
REQ-010 cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
REQ-011 cmd_mode  in  2  00 absolute, 01 relative, 10 dwell, 11 set-position.
REQ-012 cmd_pen  in  1  requested end-effector state.
REQ-013 cmd_angle  in  NJ*ANG_W  per-joint angle; joint j at [j*ANG_W +: ANG_W].
REQ-014 step_valid  out  1  step beat offered.
REQ-015 step_ready  in  1  driver accepts beat.
REQ-016 step_count  out  NJ*STEP_W  per-joint steps this beat.
REQ-017 step_dir  out  NJ  per-joint direction; 1 = positive.
REQ-018 pen_out  out  1  end-effector drive.
REQ-019 cur_angle  out  NJ*ANG_W  tracked joint angles.
REQ-020 busy  out  1  high whenever state is not IDLE.

Function
REQ-021 SHALL implement states IDLE, CALC, ISSUE, DWELL; cmd_ready = (state==IDLE) & ~reset.
REQ-022 On accept (IDLE): latch cmd; pen_out <= cmd_pen at the same edge; mode 00/01 -> CALC, 10 -> DWELL, 11 -> cur_angle <= cmd_angle, stay IDLE.
REQ-023 Target: absolute = cmd_angle; relative = cur_angle + cmd_angle saturated to signed ANG_W range per joint.
REQ-024 CALC (one cycle): diff_j = target_j - cur_j in ANG_W+1 bits; dir_j = diff_j > 0; rem_j = |diff_j| >> SHIFT; discarded LSBs remain as residual error (cur not moved for them).
REQ-025 CALC: if every rem_j == 0 -> IDLE without any beat; else -> ISSUE.
REQ-026 Latency: command accepted at edge N -> step_valid high after edge N+2.
REQ-027 ISSUE: step_count_j = min(rem_j, 2^STEP_W-1); step_valid high; step_count/step_dir stable until transfer.
REQ-028 On step_valid & step_ready: rem_j -= chunk_j; cur_j += (dir_j ? +1 : -1) * (chunk_j << SHIFT); if all rem_j now zero -> IDLE, else next beat presented at the following edge (step_valid may stay high).
REQ-029 Joints with rem_j == 0 SHALL emit step_count_j = 0, step_dir_j = 0.
REQ-030 cmd_valid while not IDLE SHALL be ignored (no accept, no state change).
REQ-031 cur_angle SHALL change only on step transfer, set-position, or reset.

Reset
REQ-032 At any edge with reset high: state IDLE, step_valid 0, step_count 0, step_dir 0, pen_out 0, busy 0, rem 0, every cur_j = HOME_ANGLE; applies mid-move (partial progress keeps nothing).

Configuration
REQ-033 Macro SCARA_SEQ_DWELL_EN defined: mode 10 enters DWELL, holds busy high and cmd_ready low exactly DWELL_CYCLES clocks, then IDLE; pen_out per REQ-022.
REQ-034 Macro SCARA_SEQ_DWELL_EN undefined: no DWELL state or counter; mode 10 accepted, pen_out updated, state stays IDLE.

Verification (NJ=2, ANG_W=14, STEP_W=8, SHIFT=2, HOME_ANGLE=0)
REQ-035 Absolute {j0=400, j1=-40}, step_ready=1 -> one beat counts {100,10}, dir {1,0}; cur {400,-40}; IDLE next cycle.
REQ-036 Absolute j0=2000 from 0 -> beats 255 then 245, dir 1; cur j0 = 2000 after second transfer.
REQ-037 Absolute j0=3 from 0 -> no step_valid pulse; IDLE after CALC; cur j0 = 0.
REQ-038 Relative j0=+8000 from cur 4000 -> target saturates 8191; rem 1047 -> beats 255,255,255,255,27; cur 8188.
REQ-039 step_ready low 10 cycles during beat -> step_valid, step_count, step_dir unchanged all 10 cycles; single transfer on first ready.
REQ-040 SCARA_SEQ_DWELL_EN defined, mode 10 pen=1, DWELL_CYCLES=200 -> pen_out 1, cmd_ready low 200 cycles; reset asserted mid-move -> step_valid 0, cur {0,0} next cycle.

Source files
------------

// File: rtl/scara_joint_sequencer.sv
// scara_joint_sequencer
// Turns absolute/relative joint-angle commands into bounded step beats for a
// multi-joint SCARA driver and tracks the resulting joint angles. It also
// handles set-position and pen (end-effector) commands.
//
// Build option: define SCARA_SEQ_DWELL_EN to make dwell commands (mode 10)
// hold the sequencer busy for DWELL_CYCLES clocks. Without it, a dwell command
// only updates pen_out.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | ready for a command; set-position and pen updates apply here
// S_CALC  | one cycle: derive per-joint direction and remaining step count
// S_ISSUE | present step beats until every joint's remaining count is zero
// S_DWELL | (SCARA_SEQ_DWELL_EN only) timed pause, down-counter to zero
module scara_joint_sequencer #(
   parameter int NJ           = 2,
   parameter int ANG_W        = 14,
   parameter int STEP_W       = 8,
   parameter int SHIFT        = 2,
   parameter int HOME_ANGLE   = 0,
   parameter int DWELL_CYCLES = 200
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic [1:0]             cmd_mode,
   input  logic                   cmd_pen,
   input  logic [NJ*ANG_W-1:0]    cmd_angle,
   output logic                   step_valid,
   input  logic                   step_ready,
   output logic [NJ*STEP_W-1:0]   step_count,
   output logic [NJ-1:0]          step_dir,
   output logic                   pen_out,
   output logic [NJ*ANG_W-1:0]    cur_angle,
   output logic                   busy
);

   localparam int REM_W = ANG_W + 1;
   localparam int CW    = (REM_W > STEP_W) ? REM_W : STEP_W;
   localparam logic [ANG_W-1:0] ANG_MAX = {1'b0, {(ANG_W-1){1'b1}}};
   localparam logic [ANG_W-1:0] ANG_MIN = {1'b1, {(ANG_W-1){1'b0}}};
   localparam logic [ANG_W-1:0] HOME    = ANG_W'(HOME_ANGLE);

`ifdef SCARA_SEQ_DWELL_EN
   localparam int DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
`endif

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CALC  = 2'd1,
      S_ISSUE = 2'd2
`ifdef SCARA_SEQ_DWELL_EN
      ,
      S_DWELL = 2'd3
`endif
   } state_t;

   state_t              r_state;
   logic [ANG_W-1:0]    r_cur      [NJ];
   logic [ANG_W-1:0]    r_target   [NJ];
   logic [REM_W-1:0]    r_rem      [NJ];
   logic [STEP_W-1:0]   r_count    [NJ];
   logic [NJ-1:0]       r_dir;
   logic [NJ-1:0]       r_step_dir;
   logic                r_step_valid;
   logic                r_pen;
`ifdef SCARA_SEQ_DWELL_EN
   logic [DW-1:0]       r_dwell_cnt;
`endif

   logic [ANG_W-1:0]    w_cmd_ang  [NJ];
   logic [REM_W-1:0]    w_sum      [NJ];
   logic [ANG_W-1:0]    w_rel_tgt  [NJ];
   logic [REM_W-1:0]    w_diff     [NJ];
   logic [REM_W-1:0]    w_mag      [NJ];
   logic [REM_W-1:0]    w_calc_rem [NJ];
   logic [REM_W-1:0]    w_rem_after[NJ];
   logic [NJ-1:0]       w_dir_calc;
   logic                w_calc_zero;
   logic                w_all_done;

   // Beat size for a joint: remaining count clamped to the step field width.
   function automatic logic [STEP_W-1:0] f_chunk(input logic [REM_W-1:0] rem);
      logic [CW-1:0] v;
      v = CW'(rem);
      if (v > CW'({STEP_W{1'b1}}))
         f_chunk = {STEP_W{1'b1}};
      else
         f_chunk = v[STEP_W-1:0];
   endfunction

   // Per-joint target, difference, step count and post-transfer remainder.
   always_comb begin
      w_calc_zero = 1'b1;
      w_all_done  = 1'b1;
      w_dir_calc  = '0;
      for (int j = 0; j < NJ; j++) begin
         w_cmd_ang[j] = cmd_angle[j*ANG_W +: ANG_W];
         w_sum[j]     = {r_cur[j][ANG_W-1], r_cur[j]} +
                        {w_cmd_ang[j][ANG_W-1], w_cmd_ang[j]};
         // Sign of the extended sum disagreeing with the ANG_W sign bit means overflow.
         if (w_sum[j][ANG_W] != w_sum[j][ANG_W-1])
            w_rel_tgt[j] = w_sum[j][ANG_W] ? ANG_MIN : ANG_MAX;
         else
            w_rel_tgt[j] = w_sum[j][ANG_W-1:0];
         w_diff[j]      = {r_target[j][ANG_W-1], r_target[j]} -
                          {r_cur[j][ANG_W-1], r_cur[j]};
         w_mag[j]       = w_diff[j][ANG_W] ? (~w_diff[j] + 1'b1) : w_diff[j];
         w_calc_rem[j]  = w_mag[j] >> SHIFT;
         w_dir_calc[j]  = ~w_diff[j][ANG_W] & (w_diff[j] != '0);
         if (w_calc_rem[j] != '0)
            w_calc_zero = 1'b0;
         w_rem_after[j] = r_rem[j] - REM_W'(r_count[j]);
         if (w_rem_after[j] != '0)
            w_all_done = 1'b0;
      end
   end

   // Sequencer FSM with registered beat, pen and angle outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_step_valid <= 1'b0;
         r_step_dir   <= '0;
         r_dir        <= '0;
         r_pen        <= 1'b0;
`ifdef SCARA_SEQ_DWELL_EN
         r_dwell_cnt  <= '0;
`endif
         for (int j = 0; j < NJ; j++) begin
            r_cur[j]    <= HOME;
            r_target[j] <= HOME;
            r_rem[j]    <= '0;
            r_count[j]  <= '0;
         end
      end else begin
         case (r_state)
            S_IDLE: begin
               if (cmd_valid) begin
                  r_pen <= cmd_pen;
                  case (cmd_mode)
                     2'b00: begin
                        for (int j = 0; j < NJ; j++) r_target[j] <= w_cmd_ang[j];
                        r_state <= S_CALC;
                     end
                     2'b01: begin
                        for (int j = 0; j < NJ; j++) r_target[j] <= w_rel_tgt[j];
                        r_state <= S_CALC;
                     end
                     2'b10: begin
`ifdef SCARA_SEQ_DWELL_EN
                        if (DWELL_CYCLES > 0) begin
                           r_dwell_cnt <= DW'(DWELL_CYCLES - 1);
                           r_state     <= S_DWELL;
                        end
`endif
                     end
                     default: begin
                        for (int j = 0; j < NJ; j++) r_cur[j] <= w_cmd_ang[j];
                     end
                  endcase
               end
            end
            S_CALC: begin
               for (int j = 0; j < NJ; j++) r_rem[j] <= w_calc_rem[j];
               r_dir   <= w_dir_calc;
               r_state <= w_calc_zero ? S_IDLE : S_ISSUE;
            end
            S_ISSUE: begin
               if (!r_step_valid) begin
                  // First beat of a move is loaded from the freshly computed remainder.
                  r_step_valid <= 1'b1;
                  for (int j = 0; j < NJ; j++) begin
                     r_count[j]    <= f_chunk(r_rem[j]);
                     r_step_dir[j] <= r_dir[j] & (r_rem[j] != '0);
                  end
               end else if (step_ready) begin
                  for (int j = 0; j < NJ; j++) begin
                     r_rem[j] <= w_rem_after[j];
                     if (r_dir[j])
                        r_cur[j] <= r_cur[j] + (ANG_W'(r_count[j]) << SHIFT);
                     else
                        r_cur[j] <= r_cur[j] - (ANG_W'(r_count[j]) << SHIFT);
                  end
                  if (w_all_done) begin
                     r_step_valid <= 1'b0;
                     r_step_dir   <= '0;
                     for (int j = 0; j < NJ; j++) r_count[j] <= '0;
                     r_state <= S_IDLE;
                  end else begin
                     for (int j = 0; j < NJ; j++) begin
                        r_count[j]    <= f_chunk(w_rem_after[j]);
                        r_step_dir[j] <= r_dir[j] & (w_rem_after[j] != '0);
                     end
                  end
               end
            end
`ifdef SCARA_SEQ_DWELL_EN
            S_DWELL: begin
               if (r_dwell_cnt == '0)
                  r_state <= S_IDLE;
               else
                  r_dwell_cnt <= r_dwell_cnt - 1'b1;
            end
`endif
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign cmd_ready  = (r_state == S_IDLE) & ~reset;
   assign busy       = (r_state != S_IDLE);
   assign step_valid = r_step_valid;
   assign step_dir   = r_step_dir;
   assign pen_out    = r_pen;

   for (genvar g = 0; g < NJ; g++) begin : g_pack
      assign step_count[g*STEP_W +: STEP_W] = r_count[g];
      assign cur_angle[g*ANG_W +: ANG_W]    = r_cur[g];
   end

endmodule

// File: tb/tb_scara_joint_sequencer.sv
// Randomized self-checking bench for scara_joint_sequencer (default parameters).
// Expected beats come from an arithmetic model: remaining steps per joint are
// |target - cur| >> SHIFT and each beat takes min(remaining, 255).
module tb_scara_joint_sequencer;

   localparam int NJ     = 2;
   localparam int ANG_W  = 14;
   localparam int STEP_W = 8;
   localparam int SHIFT  = 2;
   localparam int DWELL  = 200;
   localparam int BEAT_MAX = 255;

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 cmd_valid;
   logic                 cmd_ready;
   logic [1:0]           cmd_mode;
   logic                 cmd_pen;
   logic [NJ*ANG_W-1:0]  cmd_angle;
   logic                 step_valid;
   logic                 step_ready;
   logic [NJ*STEP_W-1:0] step_count;
   logic [NJ-1:0]        step_dir;
   logic                 pen_out;
   logic [NJ*ANG_W-1:0]  cur_angle;
   logic                 busy;

   int n_cmp = 0;
   int n_err = 0;
   int m_cur [NJ];

   scara_joint_sequencer #(
      .NJ(NJ), .ANG_W(ANG_W), .STEP_W(STEP_W), .SHIFT(SHIFT),
      .HOME_ANGLE(0), .DWELL_CYCLES(DWELL)
   ) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
      .cmd_pen(cmd_pen), .cmd_angle(cmd_angle),
      .step_valid(step_valid), .step_ready(step_ready),
      .step_count(step_count), .step_dir(step_dir),
      .pen_out(pen_out), .cur_angle(cur_angle), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic int get_cur(input int j);
      logic [ANG_W-1:0] v;
      v = cur_angle[j*ANG_W +: ANG_W];
      return int'($signed(v));
   endfunction

   function automatic int get_cnt(input int j);
      logic [STEP_W-1:0] v;
      v = step_count[j*STEP_W +: STEP_W];
      return int'(v);
   endfunction

   function automatic int sat(input int v);
      if (v > 8191) return 8191;
      if (v < -8192) return -8192;
      return v;
   endfunction

   function automatic int rnd_ang();
      return int'($urandom_range(16383)) - 8192;
   endfunction

   task automatic run_set(input int a0, input int a1, input bit pen);
      @(negedge clk);
      cmd_valid = 1'b1; cmd_mode = 2'b11; cmd_pen = pen;
      cmd_angle[0 +: ANG_W] = ANG_W'(a0);
      cmd_angle[ANG_W +: ANG_W] = ANG_W'(a1);
      n_cmp++;
      if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL set_ready: got %b expected 1", cmd_ready); end
      @(negedge clk);
      cmd_valid = 1'b0;
      m_cur[0] = a0; m_cur[1] = a1;
      for (int j = 0; j < NJ; j++) begin
         n_cmp++;
         if (get_cur(j) !== m_cur[j]) begin n_err++; $display("FAIL set_cur%0d: got %0d expected %0d", j, get_cur(j), m_cur[j]); end
      end
      n_cmp++;
      if (busy !== 1'b0 || cmd_ready !== 1'b1 || pen_out !== pen) begin
         n_err++; $display("FAIL set_idle: busy=%b ready=%b pen=%b expected 0 1 %b", busy, cmd_ready, pen_out, pen);
      end
   endtask

   task automatic run_move(input int mode, input int a0, input int a1, input bit pen,
                           input int rdy_pct, input int stall, input bit inject);
      int ang [NJ];
      int rem [NJ];
      bit dirp[NJ];
      int tgt, diff, ec, cyc, st;
      bit any, rdy, ed;
      ang[0] = a0; ang[1] = a1;
      any = 1'b0;
      st = stall;
      for (int j = 0; j < NJ; j++) begin
         tgt     = (mode == 0) ? ang[j] : sat(m_cur[j] + ang[j]);
         diff    = tgt - m_cur[j];
         dirp[j] = diff > 0;
         rem[j]  = ((diff < 0) ? -diff : diff) >> SHIFT;
         if (rem[j] > 0) any = 1'b1;
      end
      @(negedge clk);
      cmd_valid = 1'b1; cmd_mode = 2'(mode); cmd_pen = pen; step_ready = 1'b0;
      for (int j = 0; j < NJ; j++) cmd_angle[j*ANG_W +: ANG_W] = ANG_W'(ang[j]);
      n_cmp++;
      if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL move_ready: got %b expected 1", cmd_ready); end
      @(negedge clk);
      cmd_valid = 1'b0;
      n_cmp++;
      if (pen_out !== pen) begin n_err++; $display("FAIL move_pen: got %b expected %b", pen_out, pen); end
      n_cmp++;
      if (busy !== 1'b1 || step_valid !== 1'b0) begin
         n_err++; $display("FAIL latency_n: busy=%b valid=%b expected 1 0", busy, step_valid);
      end
      @(negedge clk);
      n_cmp++;
      if (step_valid !== 1'b0) begin n_err++; $display("FAIL latency_n1: valid=%b expected 0", step_valid); end
      @(negedge clk);
      n_cmp++;
      if (step_valid !== any) begin n_err++; $display("FAIL latency_n2: valid=%b expected %b", step_valid, any); end
      cyc = 0;
      while (any && cyc < 400) begin
         n_cmp++;
         if (step_valid !== 1'b1 || cmd_ready !== 1'b0) begin
            n_err++; $display("FAIL beat_valid: valid=%b ready=%b expected 1 0", step_valid, cmd_ready);
         end
         for (int j = 0; j < NJ; j++) begin
            ec = (rem[j] > BEAT_MAX) ? BEAT_MAX : rem[j];
            ed = dirp[j] && (rem[j] > 0);
            n_cmp++;
            if (get_cnt(j) !== ec) begin n_err++; $display("FAIL beat_count%0d: got %0d expected %0d", j, get_cnt(j), ec); end
            n_cmp++;
            if (step_dir[j] !== ed) begin n_err++; $display("FAIL beat_dir%0d: got %b expected %b", j, step_dir[j], ed); end
            n_cmp++;
            if (get_cur(j) !== m_cur[j]) begin n_err++; $display("FAIL beat_cur%0d: got %0d expected %0d", j, get_cur(j), m_cur[j]); end
         end
         if (st > 0) begin
            rdy = 1'b0; st--;
            if (inject) begin
               cmd_valid = 1'b1; cmd_mode = 2'b11;
               cmd_angle = (NJ*ANG_W)'($urandom);
            end
         end else begin
            cmd_valid = 1'b0;
            rdy = ($urandom_range(99) < rdy_pct);
         end
         step_ready = rdy;
         @(negedge clk);
         cyc++;
         if (rdy) begin
            any = 1'b0;
            for (int j = 0; j < NJ; j++) begin
               ec = (rem[j] > BEAT_MAX) ? BEAT_MAX : rem[j];
               m_cur[j] += dirp[j] ? (ec << SHIFT) : -(ec << SHIFT);
               rem[j] -= ec;
               if (rem[j] > 0) any = 1'b1;
            end
         end
      end
      step_ready = 1'b0; cmd_valid = 1'b0;
      if (cyc >= 400) begin n_cmp++; n_err++; $display("FAIL move_timeout: got %0d cycles expected < 400", cyc); end
      n_cmp++;
      if (step_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
         n_err++; $display("FAIL move_end: valid=%b busy=%b ready=%b expected 0 0 1", step_valid, busy, cmd_ready);
      end
      for (int j = 0; j < NJ; j++) begin
         n_cmp++;
         if (get_cur(j) !== m_cur[j]) begin n_err++; $display("FAIL end_cur%0d: got %0d expected %0d", j, get_cur(j), m_cur[j]); end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; cmd_valid = 1'b0; cmd_mode = 2'b00; cmd_pen = 1'b0;
      cmd_angle = '0; step_ready = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b expected 0", cmd_ready); end
      reset = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (step_valid !== 1'b0 || busy !== 1'b0 || pen_out !== 1'b0 || step_dir !== '0 || step_count !== '0) begin
         n_err++; $display("FAIL reset_outputs: valid=%b busy=%b pen=%b dir=%b cnt=%h expected all zero",
                           step_valid, busy, pen_out, step_dir, step_count);
      end
      n_cmp++;
      if (cur_angle !== '0 || cmd_ready !== 1'b1) begin
         n_err++; $display("FAIL reset_cur: cur=%h ready=%b expected 0 1", cur_angle, cmd_ready);
      end
      m_cur[0] = 0; m_cur[1] = 0;
   endtask

   task automatic test_basic();
      run_move(0, 400, -40, 1'b1, 100, 0, 1'b0);
      n_cmp++;
      if (get_cur(0) !== 400 || get_cur(1) !== -40) begin
         n_err++; $display("FAIL basic_cur: got %0d,%0d expected 400,-40", get_cur(0), get_cur(1));
      end
   endtask

   task automatic test_chunking();
      run_set(0, 0, 1'b0);
      run_move(0, 2000, 0, 1'b0, 100, 0, 1'b0);
      n_cmp++;
      if (get_cur(0) !== 2000) begin n_err++; $display("FAIL chunk_cur: got %0d expected 2000", get_cur(0)); end
   endtask

   task automatic test_residual();
      run_set(0, 0, 1'b0);
      run_move(0, 3, -3, 1'b1, 100, 0, 1'b0);
      n_cmp++;
      if (get_cur(0) !== 0 || get_cur(1) !== 0) begin
         n_err++; $display("FAIL residual_cur: got %0d,%0d expected 0,0", get_cur(0), get_cur(1));
      end
   endtask

   task automatic test_saturation();
      run_set(4000, -4000, 1'b0);
      run_move(1, 8000, -8000, 1'b0, 70, 0, 1'b0);
      n_cmp++;
      if (get_cur(0) !== 8188 || get_cur(1) !== -8192) begin
         n_err++; $display("FAIL sat_cur: got %0d,%0d expected 8188,-8192", get_cur(0), get_cur(1));
      end
   endtask

   task automatic test_stall();
      run_set(0, 0, 1'b0);
      run_move(0, 1000, -1000, 1'b1, 100, 10, 1'b1);
   endtask

   task automatic test_dwell();
      @(negedge clk);
      cmd_valid = 1'b1; cmd_mode = 2'b10; cmd_pen = 1'b1;
      n_cmp++;
      if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL dwell_accept: got %b expected 1", cmd_ready); end
`ifdef SCARA_SEQ_DWELL_EN
      for (int k = 0; k < DWELL; k++) begin
         @(negedge clk);
         cmd_valid = (k < DWELL - 2); cmd_mode = 2'b11;
         n_cmp++;
         if (cmd_ready !== 1'b0 || busy !== 1'b1 || pen_out !== 1'b1) begin
            n_err++; $display("FAIL dwell_hold: k=%0d ready=%b busy=%b pen=%b expected 0 1 1", k, cmd_ready, busy, pen_out);
         end
      end
      @(negedge clk);
`else
      @(negedge clk);
      cmd_valid = 1'b0;
`endif
      cmd_valid = 1'b0;
      n_cmp++;
      if (cmd_ready !== 1'b1 || busy !== 1'b0 || pen_out !== 1'b1) begin
         n_err++; $display("FAIL dwell_end: ready=%b busy=%b pen=%b expected 1 0 1", cmd_ready, busy, pen_out);
      end
      for (int j = 0; j < NJ; j++) begin
         n_cmp++;
         if (get_cur(j) !== m_cur[j]) begin n_err++; $display("FAIL dwell_cur%0d: got %0d expected %0d", j, get_cur(j), m_cur[j]); end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 25; i++) begin
         if ($urandom_range(4) == 0)
            run_set(rnd_ang(), rnd_ang(), 1'($urandom_range(1)));
         run_move(int'($urandom_range(1)), rnd_ang(), rnd_ang(), 1'($urandom_range(1)),
                  int'($urandom_range(100, 30)), int'($urandom_range(3)), 1'($urandom_range(1)));
      end
   endtask

   task automatic test_back_to_back();
      run_move(0, -6000, 5000, 1'b0, 100, 0, 1'b0);
      run_move(1, 1234, -777, 1'b1, 100, 0, 1'b0);
      run_move(0, 0, 0, 1'b0, 100, 0, 1'b0);
   endtask

   task automatic test_reset_midmove();
      run_set(0, 0, 1'b1);
      @(negedge clk);
      cmd_valid = 1'b1; cmd_mode = 2'b00; cmd_pen = 1'b1; step_ready = 1'b1;
      cmd_angle[0 +: ANG_W] = ANG_W'(8000);
      cmd_angle[ANG_W +: ANG_W] = ANG_W'(-8000);
      @(negedge clk);
      cmd_valid = 1'b0;
      repeat (4) @(negedge clk);
      n_cmp++;
      if (get_cur(0) === 0) begin n_err++; $display("FAIL midmove_progress: got %0d expected nonzero", get_cur(0)); end
      reset = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (step_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b0 || pen_out !== 1'b0) begin
         n_err++; $display("FAIL midreset_ctl: valid=%b busy=%b ready=%b pen=%b expected 0 0 0 0",
                           step_valid, busy, cmd_ready, pen_out);
      end
      n_cmp++;
      if (get_cur(0) !== 0 || get_cur(1) !== 0 || step_count !== '0 || step_dir !== '0) begin
         n_err++; $display("FAIL midreset_cur: cur=%0d,%0d cnt=%h dir=%b expected 0,0 0 0",
                           get_cur(0), get_cur(1), step_count, step_dir);
      end
      reset = 1'b0; step_ready = 1'b0;
      m_cur[0] = 0; m_cur[1] = 0;
      run_move(0, 100, 100, 1'b0, 100, 0, 1'b0);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_chunking();
      test_residual();
      test_saturation();
      test_stall();
      test_dwell();
      test_random();
      test_back_to_back();
      test_reset_midmove();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
